// File: rtl/mic_spi_reader_pkg.sv
// ----------------------------------------------------------------------------
// mic_pkg
// Shared definitions for the microphone ADC serial front end.
//   state_t     : reader FSM states (IDLE, SETUP, SHIFT, DONE)
//   FRAME_BITS  : bits clocked out of the ADC per conversion
//   DATA_BITS   : sample bits at the bottom of the frame
//   LEAD_BITS   : leading bits that the ADC always sends as zero
// ----------------------------------------------------------------------------
package mic_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SHIFT,
      DONE
   } state_t;

   localparam int FRAME_BITS = 16;
   localparam int DATA_BITS  = 12;
   localparam int LEAD_BITS  = 4;

endpackage

// File: rtl/mic_spi_reader_if.sv
// ----------------------------------------------------------------------------
// mic_spi_reader_if
// Bundles the ADC serial pins and the sample stream of the microphone reader.
//   en           : conversion enable (into the reader)
//   mic_sdata    : ADC serial data (into the reader, asynchronous)
//   mic_cs_n     : ADC chip select, active low (out of the reader)
//   mic_sclk     : ADC serial clock, idles high (out of the reader)
//   sample       : last completed conversion (out of the reader)
//   sample_valid : one-cycle strobe when sample updates (out of the reader)
//   lead_err     : leading bits of the last frame were not zero (out)
// Modports: master = the reader, slave = the ADC/consumer side.
// ----------------------------------------------------------------------------
interface mic_spi_reader_if;

   logic                          en;
   logic                          mic_sdata;
   logic                          mic_cs_n;
   logic                          mic_sclk;
   logic [mic_pkg::DATA_BITS-1:0] sample;
   logic                          sample_valid;
   logic                          lead_err;

   modport master (
      input  en,
      input  mic_sdata,
      output mic_cs_n,
      output mic_sclk,
      output sample,
      output sample_valid,
      output lead_err
   );

   modport slave (
      output en,
      output mic_sdata,
      input  mic_cs_n,
      input  mic_sclk,
      input  sample,
      input  sample_valid,
      input  lead_err
   );

endinterface

// File: rtl/mic_spi_reader_sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous input. Reusable for any
// slow asynchronous Pmod input.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset
//   i_d     : asynchronous input
//   o_q     : synchronized output (two cycles of latency)
// ----------------------------------------------------------------------------
module sync_2ff #(
   parameter bit RESET_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // First flop may go metastable; second flop gives it a full cycle to settle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/mic_spi_reader.sv
// ----------------------------------------------------------------------------
// mic_spi_reader
// Serial front end for an ADCS7476-type microphone ADC. Starts a conversion
// on every sample tick while enabled, clocks in the 16-bit frame MSB first
// and presents a held 12-bit sample with a one-cycle valid strobe.
//   CLK_DIV    : clk_in cycles per SCLK half-period (>= 4)
//   SAMPLE_DIV : clk_in cycles between conversion starts (>= 35*CLK_DIV)
//   clk_in     : system clock
//   rst_n      : asynchronous active-low reset
//   bus        : master side of mic_spi_reader_if (en, mic_sdata in;
//                mic_cs_n, mic_sclk, sample, sample_valid, lead_err out)
// ----------------------------------------------------------------------------
module mic_spi_reader
   import mic_pkg::*;
#(
   parameter int CLK_DIV    = 50,
   parameter int SAMPLE_DIV = 5000
) (
   input  logic             clk_in,
   input  logic             rst_n,
   mic_spi_reader_if.master bus
);

   localparam int TICK_W = $clog2(SAMPLE_DIV);
   localparam int HALF_W = $clog2(CLK_DIV);
   localparam int BIT_W  = $clog2(FRAME_BITS);

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
   localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_BITS - 1);

   // A frame takes 33*CLK_DIV+1 cycles plus quiet time; smaller dividers
   // would let a frame overrun the next tick or shorten the capture margin.
   generate
      if (CLK_DIV < 4) begin : g_badClkDiv
         $error("mic_spi_reader: CLK_DIV must be >= 4");
      end
      if (SAMPLE_DIV < 35 * CLK_DIV) begin : g_badSampleDiv
         $error("mic_spi_reader: SAMPLE_DIV must be >= 35*CLK_DIV");
      end
   endgenerate

   state_t                r_state;
   state_t                w_nextState;
   logic [TICK_W-1:0]     r_tickCnt;
   logic                  w_tick;
   logic [HALF_W-1:0]     r_halfCnt;
   logic                  w_halfDone;
   logic                  r_phaseHigh;
   logic                  w_nextPhaseHigh;
   logic [BIT_W-1:0]      r_bitCnt;
   logic                  w_lastBit;
   logic                  w_capture;
   logic [FRAME_BITS-1:0] r_shift;
   logic                  w_sdataSync;

   logic                  r_csN;
   logic                  r_sclk;
   logic [DATA_BITS-1:0]  r_sample;
   logic                  r_sampleValid;
   logic                  r_leadErr;
   logic                  w_nextCsN;
   logic                  w_nextSclk;
   logic                  w_nextValid;

   // mic_sdata comes straight off the Pmod pin, so resynchronize it first.
   sync_2ff #(
      .RESET_VAL(1'b0)
   ) u_sdataSync (
      .i_clk  (clk_in),
      .i_rst_n(rst_n),
      .i_d    (bus.mic_sdata),
      .o_q    (w_sdataSync)
   );

   assign w_tick     = (r_tickCnt == TICK_LAST);
   assign w_halfDone = (r_halfCnt == HALF_LAST);
   assign w_lastBit  = (r_bitCnt == BIT_LAST);
   // Capture on the edge that ends a low phase, i.e. the SCLK rising edge.
   assign w_capture  = (r_state == SHIFT) && w_halfDone && !r_phaseHigh;

   // Free-running sample-rate counter; it keeps running while disabled so the
   // tick grid stays fixed relative to reset.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_tickCnt <= '0;
      end else if (w_tick) begin
         r_tickCnt <= '0;
      end else begin
         r_tickCnt <= r_tickCnt + 1'b1;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // FSM next-state logic. Each SHIFT bit is a low half followed by a high
   // half; the frame ends when the high half of the last bit expires. en is
   // only consulted at a tick, so dropping it mid-frame lets the frame finish.
   always_comb begin
      w_nextState     = r_state;
      w_nextPhaseHigh = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_tick && bus.en) begin
               w_nextState = SETUP;
            end
         end
         SETUP: begin
            if (w_halfDone) begin
               w_nextState = SHIFT;
            end
         end
         SHIFT: begin
            w_nextPhaseHigh = w_halfDone ? !r_phaseHigh : r_phaseHigh;
            if (w_halfDone && r_phaseHigh && w_lastBit) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // FSM output logic, computed from the upcoming state so that every pin
   // can be driven straight from a flop.
   always_comb begin
      w_nextCsN   = !((w_nextState == SETUP) || (w_nextState == SHIFT));
      w_nextSclk  = !((w_nextState == SHIFT) && !w_nextPhaseHigh);
      w_nextValid = (w_nextState == DONE);
   end

   // Half-period, phase and bit counters plus the shift register. Counters
   // are held at zero outside the frame so every frame starts clean.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_halfCnt   <= '0;
         r_phaseHigh <= 1'b0;
         r_bitCnt    <= '0;
         r_shift     <= '0;
      end else begin
         if (((r_state == SETUP) || (r_state == SHIFT)) && !w_halfDone) begin
            r_halfCnt <= r_halfCnt + 1'b1;
         end else begin
            r_halfCnt <= '0;
         end
         r_phaseHigh <= w_nextPhaseHigh;
         if (r_state != SHIFT) begin
            r_bitCnt <= '0;
         end else if (w_halfDone && r_phaseHigh) begin
            r_bitCnt <= r_bitCnt + 1'b1;
         end
         if (w_capture) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], w_sdataSync};
         end
      end
   end

   // Registered outputs. The sample is loaded on the edge entering DONE so
   // it appears together with sample_valid; it is kept even when the leading
   // bits are bad, with lead_err flagging the problem.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_csN         <= 1'b1;
         r_sclk        <= 1'b1;
         r_sampleValid <= 1'b0;
         r_sample      <= '0;
         r_leadErr     <= 1'b0;
      end else begin
         r_csN         <= w_nextCsN;
         r_sclk        <= w_nextSclk;
         r_sampleValid <= w_nextValid;
         if (w_nextValid) begin
            r_sample  <= r_shift[DATA_BITS-1:0];
            r_leadErr <= |r_shift[FRAME_BITS-1 -: LEAD_BITS];
         end
      end
   end

   assign bus.mic_cs_n     = r_csN;
   assign bus.mic_sclk     = r_sclk;
   assign bus.sample       = r_sample;
   assign bus.sample_valid = r_sampleValid;
   assign bus.lead_err     = r_leadErr;

endmodule

// File: tb/tb_mic_spi_reader.sv
// ----------------------------------------------------------------------------
// tb_mic_spi_reader
// Self-checking bench for mic_spi_reader. An ADC model serves words on the
// serial pins, a frame-level model predicts each conversion from the tick
// grid and en, and a monitor compares every sample_valid against a queue.
// ----------------------------------------------------------------------------
module tb_mic_spi_reader;

   localparam int CD           = 50;
   localparam int SD           = 5000;
   localparam int FRAME_CYCLES = 33 * CD;

   typedef struct {
      logic [11:0] sample;
      logic        lead;
      int          cyc;
   } exp_t;

   logic clk_in = 1'b0;
   logic rst_n  = 1'b1;

   mic_spi_reader_if busIf ();

   mic_spi_reader #(
      .CLK_DIV   (CD),
      .SAMPLE_DIV(SD)
   ) dut (
      .clk_in(clk_in),
      .rst_n (rst_n),
      .bus   (busIf)
   );

   always #5 clk_in = ~clk_in;

   int          testsRun    = 0;
   int          testsFailed = 0;
   int          cyc         = 0;
   int          relCyc      = 0;
   int          validCnt    = 0;
   int          csFalls     = 0;
   int          holdErr     = 0;
   int          idleErr     = 0;
   exp_t        expQ[$];
   logic [15:0] wordQ[$];
   logic [15:0] curWord     = 16'h0000;
   bit          noisy       = 1'b0;
   logic [11:0] lastSample  = 12'h000;
   logic        lastLead    = 1'b0;

   // One comparison: counts it and reports a mismatch on a single line.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                  name, actual, actual, expected, expected);
      end
   endtask

   // Queue a word for the ADC to return on a future conversion.
   task automatic applyStimulus(input logic [15:0] word);
      wordQ.push_back(word);
   endtask

   // Wait for n more sample_valid pulses, giving up after a bounded time.
   task automatic waitFrames(input int n);
      int start;
      int budget;
      start  = validCnt;
      budget = SD * (n + 1) + 200;
      while ((validCnt - start < n) && (budget > 0)) begin
         @(negedge clk_in);
         budget--;
      end
      checkOutput("framesCompleted", validCnt - start, n);
   endtask

   // Wait for the next chip-select fall, giving up after one tick period.
   task automatic waitCsFall();
      int start;
      int budget;
      start  = csFalls;
      budget = SD + 200;
      while ((csFalls == start) && (budget > 0)) begin
         @(negedge clk_in);
         budget--;
      end
      checkOutput("csFallSeen", csFalls - start, 1);
   endtask

   // Frame-level model: a conversion starts at every SAMPLE_DIV-th edge after
   // reset release where en is high, and its result is due 33*CLK_DIV cycles
   // after chip select falls. The word it will return is chosen here.
   always @(posedge clk_in) begin : modelProc
      logic [15:0] w;
      exp_t        e;
      cyc++;
      if (!rst_n) begin
         relCyc = cyc;
      end else if ((cyc > relCyc) && ((cyc - relCyc) % SD == 0) && busIf.en) begin
         w        = (wordQ.size() > 0) ? wordQ.pop_front() : 16'($urandom);
         curWord  = w;
         e.sample = w[11:0];
         e.lead   = |w[15:12];
         e.cyc    = cyc + FRAME_CYCLES;
         expQ.push_back(e);
      end
   end

   // ADC model: presents the next bit after each SCLK fall while selected.
   // In noisy mode the line toggles randomly except around capture points.
   always @(negedge clk_in) begin : adcProc
      int   fallCnt;
      int   phaseCnt;
      logic prevSclkD;
      logic bitVal;
      bit   stable;
      if (!rst_n || busIf.mic_cs_n) begin
         fallCnt         = 0;
         phaseCnt        = 0;
         prevSclkD       = 1'b1;
         busIf.mic_sdata = (noisy && rst_n) ? 1'($urandom) : 1'b0;
      end else begin
         if (prevSclkD && !busIf.mic_sclk) begin
            fallCnt++;
            phaseCnt = 0;
         end else if (!prevSclkD && busIf.mic_sclk) begin
            phaseCnt = 0;
         end else begin
            phaseCnt++;
         end
         bitVal = ((fallCnt > 0) && (fallCnt <= 16)) ? curWord[16 - fallCnt] : 1'b0;
         stable = busIf.mic_sclk ? (phaseCnt < 3) : (phaseCnt >= CD - 6);
         busIf.mic_sdata = (noisy && !stable) ? 1'($urandom) : bitVal;
         prevSclkD = busIf.mic_sclk;
      end
   end

   // Monitor: checks frame start time, SCLK edge count, idle levels, held
   // outputs, and pops the scoreboard on every sample_valid.
   always @(negedge clk_in) begin : monProc
      logic prevCs;
      logic prevSclkM;
      int   riseCnt;
      exp_t e;
      if (!rst_n) begin
         prevCs    = 1'b1;
         prevSclkM = 1'b1;
         riseCnt   = 0;
      end else begin
         if (prevCs && !busIf.mic_cs_n) begin
            csFalls++;
            riseCnt = 0;
            checkOutput("csFallCycle", cyc,
                        (expQ.size() > 0) ? expQ[0].cyc - FRAME_CYCLES : -1);
         end
         if (!busIf.mic_cs_n && busIf.mic_sclk && !prevSclkM) begin
            riseCnt++;
         end
         if (!prevCs && busIf.mic_cs_n) begin
            checkOutput("sclkRisesPerFrame", riseCnt, 16);
         end
         if (busIf.mic_cs_n && !busIf.mic_sclk) begin
            idleErr++;
         end
         if (busIf.sample_valid) begin
            validCnt++;
            if (expQ.size() == 0) begin
               checkOutput("validWithoutFrame", 32'(busIf.sample_valid), 0);
            end else begin
               e = expQ.pop_front();
               checkOutput("sample", 32'(busIf.sample), 32'(e.sample));
               checkOutput("leadErr", 32'(busIf.lead_err), 32'(e.lead));
               checkOutput("validCycle", cyc, e.cyc);
               checkOutput("csRiseWithValid", 32'(busIf.mic_cs_n), 1);
               lastSample = e.sample;
               lastLead   = e.lead;
            end
         end else if ((busIf.sample !== lastSample) || (busIf.lead_err !== lastLead)) begin
            holdErr++;
         end
         prevCs    = busIf.mic_cs_n;
         prevSclkM = busIf.mic_sclk;
      end
   end

   // Main test sequence.
   initial begin : mainProc
      int vStart;
      int fStart;
      busIf.en        = 1'b0;
      busIf.mic_sdata = 1'b0;

      // Reset values.
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk_in);
      checkOutput("resetCsN", 32'(busIf.mic_cs_n), 1);
      checkOutput("resetSclk", 32'(busIf.mic_sclk), 1);
      checkOutput("resetSample", 32'(busIf.sample), 0);
      checkOutput("resetValid", 32'(busIf.sample_valid), 0);
      checkOutput("resetLeadErr", 32'(busIf.lead_err), 0);
      @(negedge clk_in);
      rst_n = 1'b1;

      // Known words: normal frame, all ones (lead error), all zeros.
      applyStimulus(16'h0ABC);
      applyStimulus(16'hFFFF);
      applyStimulus(16'h0000);
      busIf.en = 1'b1;
      waitFrames(3);

      // Continuous random frames with a noisy data line.
      noisy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(16'($urandom));
      end
      waitFrames(5);

      // Disabled across two ticks: no frames, sample holds.
      busIf.en = 1'b0;
      vStart   = validCnt;
      fStart   = csFalls;
      repeat (2 * SD + 100) @(negedge clk_in);
      checkOutput("noValidWhenDisabled", validCnt - vStart, 0);
      checkOutput("noCsWhenDisabled", csFalls - fStart, 0);

      // en dropped mid-frame: the frame still completes.
      busIf.en = 1'b1;
      waitCsFall();
      repeat (300) @(negedge clk_in);
      busIf.en = 1'b0;
      waitFrames(1);

      // Reset 800 cycles into a frame, then a clean frame after release.
      busIf.en = 1'b1;
      waitCsFall();
      repeat (800) @(negedge clk_in);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("midResetCsN", 32'(busIf.mic_cs_n), 1);
      checkOutput("midResetSclk", 32'(busIf.mic_sclk), 1);
      checkOutput("midResetSample", 32'(busIf.sample), 0);
      checkOutput("midResetValid", 32'(busIf.sample_valid), 0);
      checkOutput("midResetLeadErr", 32'(busIf.lead_err), 0);
      expQ.delete();
      lastSample = 12'h000;
      lastLead   = 1'b0;
      vStart     = validCnt;
      repeat (5) @(negedge clk_in);
      applyStimulus(16'h0123);
      rst_n = 1'b1;
      repeat (10) @(negedge clk_in);
      checkOutput("noValidAfterAbort", validCnt - vStart, 0);
      waitFrames(1);

      checkOutput("sclkHighWhileDeselected", idleErr, 0);
      checkOutput("outputsHeldBetweenFrames", holdErr, 0);
      checkOutput("leftoverExpected", expQ.size(), 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
